regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WB2RF_WD, default 70, width of write-back bus {we[69], waddr[68:64], wdata[63:0]}.
REQ-002 SHALL have parameter REG_NUM, default 32, number of architectural integer registers.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wb2rf_bus  input  WB2RF_WD  write-back request from the WB stage.
REQ-006 SHALL have port flush  input  1  pipeline flush; clears scoreboard.
REQ-007 SHALL have port sb_set_en  input  1  decode issues an instruction writing sb_set_addr.
REQ-008 SHALL have port sb_set_addr  input  5  destination register of the issuing instruction.
REQ-009 SHALL have ports rs1_addr, rs2_addr  input  5  each, read addresses.
REQ-010 SHALL have ports rs1_data, rs2_data  output  64  each, read data.
REQ-011 SHALL have ports rs1_busy, rs2_busy  output  1  each, source has a pending write.
REQ-012 SHALL have port busy_vec  output  REG_NUM  current registered scoreboard bits.

Function
REQ-013 SHALL hold REG_NUM x 64-bit registers; register 0 reads 0 always, writes to it discarded.
REQ-014 SHALL write wdata to waddr at the clock edge when we=1 and waddr!=0; one write per cycle.
REQ-015 SHALL provide two independent combinational read ports (zero-cycle latency from address).
REQ-016 SHALL set busy[sb_set_addr] at the edge when sb_set_en=1 and sb_set_addr!=0.
REQ-017 SHALL clear busy[waddr] at the edge when we=1 (WB retirement).
REQ-018 SHALL, on simultaneous set and clear of the same register, leave it set (newer producer wins).
REQ-019 SHALL, on flush=1, clear all busy bits at the edge, ignoring a same-cycle sb_set_en; the WB write in that cycle still updates the array.
REQ-020 SHALL keep busy[0] and rsX_busy for address 0 at 0 permanently.
REQ-021 SHALL make rsX_busy equal busy[rsX_addr] subject to REQ-024 bypass rule.
REQ-022 SHALL not depend on sb_set_* combinationally for any output (no same-cycle self-hazard).

Reset
REQ-023 SHALL, while rst=1, asynchronously clear all registers to 0, all busy bits to 0; hence rs1_data, rs2_data, rs1_busy, rs2_busy, busy_vec read 0; a reset mid-write discards that write.

Configuration
REQ-024 SHALL, with macro RF_BYPASS_EN defined, return wdata on rsX_data and drive rsX_busy=0 when we=1 and waddr==rsX_addr!=0 in the same cycle.
REQ-025 SHALL, without RF_BYPASS_EN, return the pre-write array value and the registered busy bit in that case; the new value is visible the following cycle.

Structure
REQ-026 SHALL place WB2RF_WD, REG_NUM, field offsets of wb2rf_bus (WE_BIT, WADDR_MSB/LSB, WDATA_MSB/LSB) and the register-address width in shared package rf_pkg, reused by WB.
REQ-027 SHALL implement the busy-bit logic (set/clear/flush priority) as sub-module rf_scoreboard; array and read muxing stay in regfile_sb.

Verification
REQ-028 SHALL test: reset, then read all 32 addresses -> all data 0, busy_vec=0.
REQ-029 SHALL test: write x5=0x0123_4567_89AB_CDEF, next cycle rs1_addr=5 -> rs1_data=0x0123_4567_89AB_CDEF; write x0=0xFFFF... -> x0 reads 0.
REQ-030 SHALL test: same-cycle write x7=0xAA and rs2_addr=7 -> rs2_data=0xAA with RF_BYPASS_EN, previous x7 value without; both builds read 0xAA next cycle.
REQ-031 SHALL test: sb_set x9, next cycle rs1_busy=1; WB we x9 -> busy[9]=0 next cycle; simultaneous set and WB clear of x9 -> busy[9]=1.
REQ-032 SHALL test: busy_vec=0x0000_0F00, flush with sb_set_en for x3 and WB write x10=0x55 -> busy_vec=0 next cycle, x10 reads 0x55.
REQ-033 SHALL test: assert rst asynchronously mid-cycle with we=1 -> outputs 0 immediately, no write committed after release.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: constants shared by the register file and the write-back stage.
//   WB2RF_WD          width of the write-back bus {we, waddr, wdata}
//   REG_NUM           number of architectural integer registers
//   RF_AW             register-address width
//   XLEN              register data width
//   WE_BIT, WADDR_*, WDATA_*   field offsets inside the write-back bus
// Helper wb2rf_pack builds a write-back bus word from its fields.
package rf_pkg;

    localparam int unsigned WB2RF_WD  = 70;
    localparam int unsigned REG_NUM   = 32;
    localparam int unsigned RF_AW     = 5;
    localparam int unsigned XLEN      = 64;

    localparam int unsigned WE_BIT    = 69;
    localparam int unsigned WADDR_MSB = 68;
    localparam int unsigned WADDR_LSB = 64;
    localparam int unsigned WDATA_MSB = 63;
    localparam int unsigned WDATA_LSB = 0;

    function automatic logic [WB2RF_WD-1:0] wb2rf_pack(
        input logic            we,
        input logic [RF_AW-1:0] waddr,
        input logic [XLEN-1:0]  wdata
    );
        logic [WB2RF_WD-1:0] bus;
        bus                        = '0;
        bus[WE_BIT]                = we;
        bus[WADDR_MSB:WADDR_LSB]   = waddr;
        bus[WDATA_MSB:WDATA_LSB]   = wdata;
        return bus;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one busy bit per architectural register.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 clears every busy bit (beats a same-cycle set)
//   set_en, set_addr      issuing instruction marks its destination busy
//   clr_en, clr_addr      write-back retirement clears the destination
//   busy                  registered busy bits; bit 0 is always 0
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned REG_NUM = rf_pkg::REG_NUM
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               set_en,
    input  logic [RF_AW-1:0]   set_addr,
    input  logic               clr_en,
    input  logic [RF_AW-1:0]   clr_addr,
    output logic [REG_NUM-1:0] busy
);

    logic [REG_NUM-1:0] busy_nxt;

    // Clear is applied before set so that a new producer issuing in the
    // same cycle an older one retires keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (clr_en) busy_nxt[clr_addr] = 1'b0;
            if (set_en) busy_nxt[set_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with write-back port, two combinational
// read ports and a busy-bit scoreboard (rf_scoreboard).
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   wb2rf_bus                   {we, waddr, wdata} from the WB stage
//   flush                       clears the scoreboard
//   sb_set_en, sb_set_addr      decode marks a destination busy
//   rs1_addr/rs2_addr           read addresses
//   rs1_data/rs2_data           read data (x0 reads 0)
//   rs1_busy/rs2_busy           source has a pending write
//   busy_vec                    registered scoreboard bits
// Configuration macro: RF_BYPASS_EN -- when defined, a same-cycle write-back
// to a read address is forwarded to the read port and reported not busy.
module regfile_sb
    import rf_pkg::*;
#(
    parameter int unsigned WB2RF_WD = rf_pkg::WB2RF_WD,
    parameter int unsigned REG_NUM  = rf_pkg::REG_NUM
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WB2RF_WD-1:0] wb2rf_bus,
    input  logic                flush,
    input  logic                sb_set_en,
    input  logic [RF_AW-1:0]    sb_set_addr,
    input  logic [RF_AW-1:0]    rs1_addr,
    input  logic [RF_AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]     rs1_data,
    output logic [XLEN-1:0]     rs2_data,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic [REG_NUM-1:0]  busy_vec
);

    logic               we;
    logic [RF_AW-1:0]   waddr;
    logic [XLEN-1:0]    wdata;
    logic [XLEN-1:0]    regs [REG_NUM];

    assign we    = wb2rf_bus[WE_BIT];
    assign waddr = wb2rf_bus[WADDR_MSB:WADDR_LSB];
    assign wdata = wb2rf_bus[WDATA_MSB:WDATA_LSB];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    rf_scoreboard #(
        .REG_NUM (REG_NUM)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .set_en   (sb_set_en),
        .set_addr (sb_set_addr),
        .clr_en   (we),
        .clr_addr (waddr),
        .busy     (busy_vec)
    );

    // Read ports look only at the array, the registered busy bits and the
    // write-back bus; sb_set_* never reaches an output in the same cycle.
    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
        rs1_busy = busy_vec[rs1_addr];
`ifdef RF_BYPASS_EN
        if (we && (waddr == rs1_addr) && (rs1_addr != '0)) begin
            rs1_data = wdata;
            rs1_busy = 1'b0;
        end
`else
`endif
    end

    always_comb begin
        rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
        rs2_busy = busy_vec[rs2_addr];
`ifdef RF_BYPASS_EN
        if (we && (waddr == rs2_addr) && (rs2_addr != '0)) begin
            rs2_data = wdata;
            rs2_busy = 1'b0;
        end
`else
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb.
// Inputs change on the falling edge; outputs are checked 1 ns later.
// Expected values are hand-computed; RF_BYPASS_EN selects the same-cycle
// read expectations.
module tb_regfile_sb;
    import rf_pkg::*;

    logic                clk;
    logic                rst;
    logic [WB2RF_WD-1:0] wb2rf_bus;
    logic                flush;
    logic                sb_set_en;
    logic [RF_AW-1:0]    sb_set_addr;
    logic [RF_AW-1:0]    rs1_addr;
    logic [RF_AW-1:0]    rs2_addr;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic                rs1_busy;
    logic                rs2_busy;
    logic [REG_NUM-1:0]  busy_vec;

    int n_assert;
    int n_fail;

    regfile_sb #(
        .WB2RF_WD (WB2RF_WD),
        .REG_NUM  (REG_NUM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb2rf_bus   (wb2rf_bus),
        .flush       (flush),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .busy_vec    (busy_vec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and return at the following falling edge.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wb2rf_bus   = '0;
        flush       = 1'b0;
        sb_set_en   = 1'b0;
        sb_set_addr = '0;
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        rs1_addr    = '0;
        rs2_addr    = '0;
        idle_inputs();

        // Reset state
        #2;
        chk("reset_busy_vec", 64'(busy_vec), 64'h0);
        chk("reset_rs1_data", rs1_data, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // All addresses read 0 after reset
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            chk($sformatf("init_rs1_x%0d", i), rs1_data, 64'h0);
            chk($sformatf("init_rs2_x%0d", 31 - i), rs2_data, 64'h0);
            chk($sformatf("init_rs1_busy_x%0d", i), 64'(rs1_busy), 64'h0);
        end
        chk("init_busy_vec", 64'(busy_vec), 64'h0);

        // Write x5, read it back next cycle
        @(negedge clk);
        wb2rf_bus = wb2rf_pack(1'b1, 5'd5, 64'h0123_4567_89AB_CDEF);
        next_cycle();
        idle_inputs();
        rs1_addr = 5'd5;
        #1;
        chk("x5_readback", rs1_data, 64'h0123_4567_89AB_CDEF);

        // Writes to x0 are discarded
        @(negedge clk);
        wb2rf_bus = wb2rf_pack(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        next_cycle();
        idle_inputs();
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        #1;
        chk("x0_rs1_zero", rs1_data, 64'h0);
        chk("x0_rs2_zero", rs2_data, 64'h0);
        chk("x0_busy_vec", 64'(busy_vec), 64'h0);

        // x7 = 0x11 while a new producer of x7 issues: set wins, x7 busy
        @(negedge clk);
        wb2rf_bus   = wb2rf_pack(1'b1, 5'd7, 64'h11);
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd7;
        next_cycle();
        idle_inputs();
        rs2_addr = 5'd7;
        #1;
        chk("x7_pre", rs2_data, 64'h11);
        chk("x7_pre_busy", 64'(rs2_busy), 64'h1);

        // Same-cycle write x7 = 0xAA with rs2 reading x7
        wb2rf_bus = wb2rf_pack(1'b1, 5'd7, 64'hAA);
        #1;
`ifdef RF_BYPASS_EN
        chk("x7_same_cycle_data", rs2_data, 64'hAA);
        chk("x7_same_cycle_busy", 64'(rs2_busy), 64'h0);
`else
        chk("x7_same_cycle_data", rs2_data, 64'h11);
        chk("x7_same_cycle_busy", 64'(rs2_busy), 64'h1);
`endif
        next_cycle();
        idle_inputs();
        #1;
        chk("x7_next_data", rs2_data, 64'hAA);
        chk("x7_next_busy", 64'(rs2_busy), 64'h0);

        // Scoreboard set of x9; no same-cycle effect on outputs
        rs1_addr    = 5'd9;
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd9;
        #1;
        chk("x9_set_same_cycle", 64'(rs1_busy), 64'h0);
        next_cycle();
        idle_inputs();
        #1;
        chk("x9_busy_after_set", 64'(rs1_busy), 64'h1);
        chk("x9_busy_vec", 64'(busy_vec), 64'h0000_0200);

        // WB retirement clears x9
        wb2rf_bus = wb2rf_pack(1'b1, 5'd9, 64'h99);
        next_cycle();
        idle_inputs();
        #1;
        chk("x9_busy_after_wb", 64'(busy_vec), 64'h0);
        chk("x9_data_after_wb", rs1_data, 64'h99);

        // Simultaneous set and clear of x9 leaves it busy
        wb2rf_bus   = wb2rf_pack(1'b1, 5'd9, 64'h9A);
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd9;
        next_cycle();
        idle_inputs();
        #1;
        chk("x9_set_and_clr", 64'(busy_vec), 64'h0000_0200);
        chk("x9_set_and_clr_rs1", 64'(rs1_busy), 64'h1);

        // Build busy_vec = 0xF00 (x9 already set)
        for (int r = 8; r <= 11; r++) begin
            sb_set_en   = 1'b1;
            sb_set_addr = 5'(r);
            next_cycle();
        end
        idle_inputs();
        #1;
        chk("busy_vec_f00", 64'(busy_vec), 64'h0000_0F00);

        // Flush with a same-cycle set of x3 and WB write of x10
        flush       = 1'b1;
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd3;
        wb2rf_bus   = wb2rf_pack(1'b1, 5'd10, 64'h55);
        next_cycle();
        idle_inputs();
        rs1_addr = 5'd10;
        rs2_addr = 5'd3;
        #1;
        chk("flush_busy_vec", 64'(busy_vec), 64'h0);
        chk("flush_x10_data", rs1_data, 64'h55);
        chk("flush_x3_busy", 64'(rs2_busy), 64'h0);

        // Asynchronous reset mid-cycle while a write of x12 is pending
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd13;
        next_cycle();
        idle_inputs();
        #1;
        chk("pre_rst_busy_x13", 64'(busy_vec), 64'h0000_2000);
        wb2rf_bus = wb2rf_pack(1'b1, 5'd12, 64'hDEAD_BEEF);
        rs1_addr  = 5'd5;
        rs2_addr  = 5'd10;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_rs1", rs1_data, 64'h0);
        chk("rst_async_rs2", rs2_data, 64'h0);
        chk("rst_async_busy_vec", 64'(busy_vec), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        rs1_addr = 5'd12;
        #1;
        chk("rst_x12_not_written", rs1_data, 64'h0);
        next_cycle();
        #1;
        chk("rst_x12_still_zero", rs1_data, 64'h0);
        chk("rst_x10_zero", rs2_data, 64'h0);
        chk("rst_busy_vec_after", 64'(busy_vec), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
